// File: rtl/copro_pkg.sv
// Shared types and constants for the coprocessor host bridge.
// Bridge FSM state encoding plus the beat-count helper used to size the response stream.
package copro_pkg;

  localparam int DATA_W  = 200;
  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 15;
  localparam int BEAT_W  = 32;
  localparam int TIMEOUT = 1023;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    RD_ADDR,
    RD_WAIT,
    STREAM,
    ERR
  } state_e;

  function automatic int nbeats(input int data_w, input int beat_w);
    return (data_w + beat_w - 1) / beat_w;
  endfunction

endpackage

// File: rtl/copro_beat_serializer.sv
// Purpose: splits one DATA_W row into ceil(DATA_W/BEAT_W) beats, LSB-first, zero-padded on top.
// Latency: first beat valid the cycle after load; one beat per accepted handshake.
// Backpressure: beat data and last flag hold while out_vld & ~out_rdy.
module copro_beat_serializer #(
  parameter int DATA_W = copro_pkg::DATA_W,
  parameter int BEAT_W = copro_pkg::BEAT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_dat,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [BEAT_W-1:0] out_dat,
  output logic              out_last
);
  import copro_pkg::*;

  localparam int NB    = nbeats(DATA_W, BEAT_W);
  localparam int PAD_W = NB * BEAT_W;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

  logic [PAD_W-1:0] sh_q, sh_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             vld_q, vld_d;
  logic             beat_hs;

  assign beat_hs  = vld_q & out_rdy;
  assign out_vld  = vld_q;
  assign out_dat  = sh_q[BEAT_W-1:0];
  assign out_last = vld_q & (idx_q == IDX_W'(NB - 1));

  always_comb begin
    sh_d  = sh_q;
    idx_d = idx_q;
    vld_d = vld_q;
    if (load) begin
      // Zero-extension supplies the padding bits of the final beat.
      sh_d  = PAD_W'(load_dat);
      idx_d = '0;
      vld_d = 1'b1;
    end else if (beat_hs) begin
      sh_d = sh_q >> BEAT_W;
      if (out_last) begin
        idx_d = '0;
        vld_d = 1'b0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q  <= '0;
      idx_q <= '0;
      vld_q <= 1'b0;
    end else begin
      sh_q  <= sh_d;
      idx_q <= idx_d;
      vld_q <= vld_d;
    end
  end

endmodule

// File: rtl/copro_host_bridge.sv
// Purpose: issues one host instruction to the coprocessor, waits for DONE, reads the result row and streams it back.
// Latency: accept -> first beat = 1 ISSUE + N wait + 2 read cycles; TIMEOUT wait cycles give a single error beat.
// Backpressure: cmd_ready only in IDLE; response beats and the error beat hold until rsp_ready.
module copro_host_bridge #(
  parameter int DATA_W  = copro_pkg::DATA_W,
  parameter int ADDR_W  = copro_pkg::ADDR_W,
  parameter int INSTR_W = copro_pkg::INSTR_W,
  parameter int BEAT_W  = copro_pkg::BEAT_W,
  parameter int TIMEOUT = copro_pkg::TIMEOUT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [INSTR_W-1:0] cmd_instr,
  input  logic [ADDR_W-1:0]  cmd_res_addr,
  output logic [INSTR_W-1:0] cop_instr,
  output logic               cop_start,
  input  logic               cop_done,
  output logic               mem_sel,
  output logic [ADDR_W-1:0]  mem_address,
  input  logic [DATA_W-1:0]  mem_q,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [BEAT_W-1:0]  rsp_data,
  output logic               rsp_last,
  output logic               rsp_err,
  output logic               busy
);
  import copro_pkg::*;

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q;
  logic               done_evt;
  logic               ser_load, ser_vld, ser_rdy, ser_last;
  logic [BEAT_W-1:0]  ser_dat;

  // Only a fresh rising edge counts, so a DONE level left over from the previous op is ignored.
  assign done_evt = cop_done & ~done_q;

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    ser_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          instr_d = cmd_instr;
          addr_d  = cmd_res_addr;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (done_evt) begin
          state_d = RD_ADDR;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RD_ADDR: state_d = RD_WAIT;
      RD_WAIT: begin
        // mem_q now reflects the address driven during RD_ADDR.
        ser_load = 1'b1;
        state_d  = STREAM;
      end
      STREAM: begin
        if (ser_vld & ser_rdy & ser_last) state_d = IDLE;
      end
      ERR: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      instr_q <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      done_q  <= cop_done;
    end
  end

  // Control outputs decode straight from the state flop so reset removes them without waiting for a clock.
  assign cmd_ready   = (state_q == IDLE);
  assign busy        = ~cmd_ready;
  assign cop_start   = (state_q == ISSUE);
  assign cop_instr   = instr_q;
  assign mem_sel     = (state_q == RD_ADDR) | (state_q == RD_WAIT);
  assign mem_address = mem_sel ? addr_q : '0;
  assign rsp_err     = (state_q == ERR);
  assign ser_rdy     = rsp_ready & (state_q == STREAM);
  assign rsp_valid   = ser_vld | rsp_err;
  assign rsp_last    = ser_last | rsp_err;
  assign rsp_data    = rsp_err ? '0 : ser_dat;

  copro_beat_serializer #(
    .DATA_W (DATA_W),
    .BEAT_W (BEAT_W)
  ) u_ser (
    .clk      (clk),
    .rst_n    (reset),
    .load     (ser_load),
    .load_dat (mem_q),
    .out_vld  (ser_vld),
    .out_rdy  (ser_rdy),
    .out_dat  (ser_dat),
    .out_last (ser_last)
  );

endmodule
